// File: rtl/exc_commit_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// exc_commit_unit_if : commit, flush-redirect and CP0-update bundle for
//                      exc_commit_unit (timer ports under EXC_TIMER_INT_EN).
// Revision: 1.0
// ---------------------------------------------------------------------------
interface exc_commit_unit_if #(
   parameter int NUM_HW_INT = 6
);
   logic                  cm_valid_i;
   logic                  cm_ready_o;
   logic [31:0]           cm_pc_i;
   logic                  cm_in_ds_i;
   logic                  cm_mem_en_i;
   logic [31:0]           cm_m_addr_i;
   logic [8:0]            cm_excs_i;
   logic [NUM_HW_INT-1:0] hw_int_i;
   logic [1:0]            sw_ip_i;
   logic [7:0]            status_im_i;
   logic                  status_ie_i;
   logic                  status_exl_i;
   logic                  status_erl_i;
   logic [31:0]           cp0_epc_i;
   logic                  flush_o;
   logic [31:0]           flush_pc_o;
   logic                  flush_ack_i;
   logic                  cp0_we_o;
   logic                  eret_o;
   logic [4:0]            exc_code_o;
   logic                  badvaddr_we_o;
   logic [31:0]           badvaddr_o;
   logic [31:0]           epc_o;
   logic                  bd_o;
   logic [7:0]            ip_o;
`ifdef EXC_TIMER_INT_EN
   logic [31:0]           cnt_o;
   logic                  cmp_we_i;
   logic [31:0]           cmp_wdata_i;
`endif

   modport slave (
      input  cm_valid_i, cm_pc_i, cm_in_ds_i, cm_mem_en_i, cm_m_addr_i, cm_excs_i,
      input  hw_int_i, sw_ip_i, status_im_i, status_ie_i, status_exl_i, status_erl_i,
      input  cp0_epc_i, flush_ack_i,
`ifdef EXC_TIMER_INT_EN
      input  cmp_we_i, cmp_wdata_i,
      output cnt_o,
`endif
      output cm_ready_o, flush_o, flush_pc_o, cp0_we_o, eret_o, exc_code_o,
      output badvaddr_we_o, badvaddr_o, epc_o, bd_o, ip_o
   );

   modport master (
      output cm_valid_i, cm_pc_i, cm_in_ds_i, cm_mem_en_i, cm_m_addr_i, cm_excs_i,
      output hw_int_i, sw_ip_i, status_im_i, status_ie_i, status_exl_i, status_erl_i,
      output cp0_epc_i, flush_ack_i,
`ifdef EXC_TIMER_INT_EN
      output cmp_we_i, cmp_wdata_i,
      input  cnt_o,
`endif
      input  cm_ready_o, flush_o, flush_pc_o, cp0_we_o, eret_o, exc_code_o,
      input  badvaddr_we_o, badvaddr_o, epc_o, bd_o, ip_o
   );
endinterface
`default_nettype wire

// File: rtl/exc_commit_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// exc_commit_unit : MEM/WB exception/interrupt resolver with held flush
//                   handshake and one-cycle CP0 update. Option: EXC_TIMER_INT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module exc_commit_unit #(
   parameter int          NUM_HW_INT  = 6,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
   parameter int          DRAIN_CYC   = 1
) (
   input  logic               clk,
   input  logic               resetn,
   exc_commit_unit_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [4:0] c_code_int  = 5'h00;
   localparam logic [4:0] c_code_adel = 5'h04;
   localparam logic [4:0] c_code_ades = 5'h05;
   localparam logic [4:0] c_code_sys  = 5'h08;
   localparam logic [4:0] c_code_bp   = 5'h09;
   localparam logic [4:0] c_code_ri   = 5'h0A;
   localparam logic [4:0] c_code_ov   = 5'h0C;
   localparam logic [2:0] c_drain_last = (DRAIN_CYC == 0) ? 3'd0 : 3'(DRAIN_CYC - 1);

   state_t                                r_state, w_state_next;
   logic [2:0]                            r_drain_cnt, w_drain_next;
   logic [SYNC_STAGES-1:0][NUM_HW_INT-1:0] r_sync;
   logic [7:0]                            r_ip, w_ip_next;
   logic                                  w_timer_ip;
   logic                                  w_int_req, w_accept, w_int_take, w_take;
   logic                                  w_is_eret, w_bva_we;
   logic [4:0]                            w_code;
   logic [31:0]                           w_bva;
   logic                                  r_cp0_we, r_eret, r_bva_we, r_bd;
   logic [4:0]                            r_code;
   logic [31:0]                           r_flush_pc, r_bva, r_epc;
   logic                                  w_unused_excs0;

   assign w_unused_excs0 = bus.cm_excs_i[0];

   // Interrupt-line synchroniser; depth 1 needs its own form (no shift slice).
   if (SYNC_STAGES == 1) begin : g_sync_one
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) r_sync <= '0;
         else         r_sync <= bus.hw_int_i;
      end
   end else begin : g_sync_chain
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) r_sync <= '0;
         else         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.hw_int_i};
      end
   end

`ifdef EXC_TIMER_INT_EN
   logic [31:0] r_count, r_compare;
   logic        r_half, r_timer_ip;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_half     <= 1'b0;
         r_count    <= '0;
         r_compare  <= '1;
         r_timer_ip <= 1'b0;
      end else begin
         r_half <= ~r_half;
         if (r_half) r_count <= r_count + 32'd1;
         if (bus.cmp_we_i) begin
            r_compare  <= bus.cmp_wdata_i;
            r_timer_ip <= 1'b0;
         end else if (r_count == r_compare) begin
            r_timer_ip <= 1'b1;
         end
      end
   end

   assign bus.cnt_o  = r_count;
   assign w_timer_ip = r_timer_ip;
`else
   assign w_timer_ip = 1'b0;
`endif

   always_comb begin
      w_ip_next      = '0;
      w_ip_next[1:0] = bus.sw_ip_i;
      for (int i = 0; i < NUM_HW_INT; i++) w_ip_next[2+i] = r_sync[SYNC_STAGES-1][i];
      w_ip_next[7]   = w_ip_next[7] | w_timer_ip;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_ip <= '0;
      else         r_ip <= w_ip_next;
   end

   assign w_int_req  = (|(r_ip & bus.status_im_i)) & bus.status_ie_i &
                       ~bus.status_exl_i & ~bus.status_erl_i;
   assign w_accept   = bus.cm_valid_i & (r_state == ST_IDLE);
   assign w_int_take = w_accept & ~bus.cm_mem_en_i & w_int_req;
   assign w_take     = w_accept & (w_int_take | (|bus.cm_excs_i[8:1]));

   // Fixed priority; ERET only when nothing else is flagged.
   always_comb begin
      w_is_eret = 1'b0;
      w_code    = c_code_int;
      w_bva_we  = 1'b0;
      w_bva     = bus.cm_pc_i;
      if (w_int_take) begin
         w_code = c_code_int;
      end else if (bus.cm_excs_i[1]) begin
         w_code   = c_code_adel;
         w_bva_we = 1'b1;
      end else if (bus.cm_excs_i[2]) begin
         w_code   = c_code_adel;
         w_bva_we = 1'b1;
         w_bva    = bus.cm_m_addr_i;
      end else if (bus.cm_excs_i[3]) begin
         w_code   = c_code_ades;
         w_bva_we = 1'b1;
         w_bva    = bus.cm_m_addr_i;
      end else if (bus.cm_excs_i[4]) begin
         w_code = c_code_ov;
      end else if (bus.cm_excs_i[5]) begin
         w_code = c_code_sys;
      end else if (bus.cm_excs_i[6]) begin
         w_code = c_code_bp;
      end else if (bus.cm_excs_i[7]) begin
         w_code = c_code_ri;
      end else begin
         w_is_eret = bus.cm_excs_i[8];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= ST_IDLE;
         r_drain_cnt <= '0;
      end else begin
         r_state     <= w_state_next;
         r_drain_cnt <= w_drain_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_drain_next = r_drain_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_take) w_state_next = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (bus.flush_ack_i) begin
               w_drain_next = '0;
               w_state_next = (DRAIN_CYC == 0) ? ST_IDLE : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (r_drain_cnt == c_drain_last) w_state_next = ST_IDLE;
            else                             w_drain_next = r_drain_cnt + 3'd1;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // CP0 fields persist until the next exception; strobes last one cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cp0_we   <= 1'b0;
         r_eret     <= 1'b0;
         r_bva_we   <= 1'b0;
         r_bd       <= 1'b0;
         r_code     <= '0;
         r_flush_pc <= '0;
         r_bva      <= '0;
         r_epc      <= '0;
      end else begin
         r_cp0_we <= 1'b0;
         r_eret   <= 1'b0;
         r_bva_we <= 1'b0;
         if (w_take) begin
            if (w_is_eret) begin
               r_eret     <= 1'b1;
               r_flush_pc <= bus.cp0_epc_i;
            end else begin
               r_cp0_we   <= 1'b1;
               r_flush_pc <= EXC_VECTOR;
               r_code     <= w_code;
               r_epc      <= bus.cm_in_ds_i ? (bus.cm_pc_i - 32'd4) : bus.cm_pc_i;
               r_bd       <= bus.cm_in_ds_i;
               r_bva_we   <= w_bva_we;
               if (w_bva_we) r_bva <= w_bva;
            end
         end
      end
   end

   assign bus.cm_ready_o    = (r_state == ST_IDLE);
   assign bus.flush_o       = (r_state == ST_FLUSH);
   assign bus.flush_pc_o    = r_flush_pc;
   assign bus.cp0_we_o      = r_cp0_we;
   assign bus.eret_o        = r_eret;
   assign bus.exc_code_o    = r_code;
   assign bus.badvaddr_we_o = r_bva_we;
   assign bus.badvaddr_o    = r_bva;
   assign bus.epc_o         = r_epc;
   assign bus.bd_o          = r_bd;
   assign bus.ip_o          = r_ip;

endmodule
`default_nettype wire

// File: doc/exc_commit_unit.md
Name: exc_commit_unit

Overview:
- Parametrised successor to the combinational exception resolver; sits at the MEM/WB commit boundary.
- Resolves per-instruction exception flags plus synchronised, masked hardware interrupts; picks one by fixed priority and registers the result.
- Drives a held flush/redirect handshake to fetch and produces CP0 update fields (ExcCode, BadVAddr, EPC, BD) for exactly one cycle.

Parameters:
- NUM_HW_INT, 6, number of external hardware interrupt lines (mapped to IP[2+:NUM_HW_INT]).
- SYNC_STAGES, 2, flip-flop synchroniser depth on each interrupt line (min 1).
- EXC_VECTOR, 32'hBFC0_0380, redirect target for every non-ERET exception.
- DRAIN_CYC, 1, dead cycles after flush acceptance before the next commit is accepted (0..7).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- cm_valid_i  in  1  instruction presented for commit.
- cm_ready_o  out  1  unit can accept a commit this cycle.
- cm_pc_i  in  32  PC of committing instruction.
- cm_in_ds_i  in  1  instruction is in a branch delay slot.
- cm_mem_en_i  in  1  instruction has an outstanding memory request.
- cm_m_addr_i  in  32  data address of the load/store.
- cm_excs_i  in  9  flags: [1] AdEL-fetch, [2] AdEL-data, [3] AdES, [4] Ov, [5] Sys, [6] Bp, [7] RI, [8] ERET; [0] ignored.
- hw_int_i  in  NUM_HW_INT  asynchronous interrupt lines, level-sensitive.
- sw_ip_i  in  2  CP0 Cause.IP[1:0].
- status_im_i  in  8  CP0 Status.IM.
- status_ie_i / status_exl_i / status_erl_i  in  1 each  CP0 Status bits.
- cp0_epc_i  in  32  CP0 EPC, used for ERET target.
- flush_o  out  1  redirect request, held until acknowledged.
- flush_pc_o  out  32  redirect target, stable while flush_o high.
- flush_ack_i  in  1  fetch accepted the redirect.
- cp0_we_o  out  1  one-cycle CP0 update strobe (non-ERET).
- eret_o  out  1  one-cycle ERET strobe (clear EXL).
- exc_code_o  out  5  MIPS ExcCode.
- badvaddr_we_o  out  1  BadVAddr write enable, same cycle as cp0_we_o.
- badvaddr_o  out  32  faulting address.
- epc_o  out  32  EPC value.
- bd_o  out  1  Cause.BD value.
- ip_o  out  8  synchronised pending vector for Cause.IP.

Behaviour:
- Reset: all outputs 0 except cm_ready_o=1; FSM IDLE; synchronisers cleared.
- ip_o = {sync(hw_int_i), sw_ip_i}, registered; upper bits beyond 2+NUM_HW_INT read 0.
- int_req = |(ip_o & status_im_i) & status_ie_i & ~status_exl_i & ~status_erl_i.
- Interrupt taken only when cm_valid_i & ~cm_mem_en_i & int_req.
- Priority: Int(0x00) > AdEL-fetch(0x04) > AdEL-data(0x04) > AdES(0x05) > Ov(0x0C) > Sys(0x08) > Bp(0x09) > RI(0x0A) > ERET.
- Commit accepted when cm_valid_i & cm_ready_o; a commit with no flag and no interrupt is transparent (no output change).
- FSM IDLE: on accepted exceptional commit, next cycle: flush_o=1, cp0_we_o or eret_o pulse for 1 cycle; go FLUSH.
- Registered values: ERET -> flush_pc_o=cp0_epc_i, no cp0_we_o; other -> flush_pc_o=EXC_VECTOR, epc_o=cm_in_ds_i ? cm_pc_i-4 : cm_pc_i (mod 2^32), bd_o=cm_in_ds_i.
- badvaddr_o = cm_pc_i for AdEL-fetch, cm_m_addr_i for AdEL-data/AdES; badvaddr_we_o only for those.
- FLUSH: cm_ready_o=0; flush_o and flush_pc_o held; on flush_ack_i go DRAIN (or IDLE if DRAIN_CYC=0), flush_o drops next cycle.
- DRAIN: cm_ready_o=0, counts DRAIN_CYC cycles, then IDLE.
- Exception with status_exl_i=1: epc_o/bd_o still driven, cp0_we_o asserted, EPC write suppression is CP0's responsibility.
- flush_ack_i in IDLE/DRAIN ignored. resetn low in any state: immediate return to reset values, pending flush dropped.

Optional Feature:
- EXC_TIMER_INT_EN: internal 32-bit Count (increments every 2nd clk) and Compare; extra ports cnt_o[31:0], cmp_we_i, cmp_wdata_i[31:0]; Count==Compare sets IP[7] sticky, cleared by cmp_we_i; IP[7] is OR'd with hw line 5.
- Without macro: no timer logic/ports; IP[7] comes only from hw_int_i[5].

Test Plan:
- Ov commit pc=0xBFC0_1000, in_ds=0 -> 1 cycle later flush_o=1, flush_pc_o=0xBFC0_0380, exc_code_o=0x0C, epc_o=0xBFC0_1000, bd_o=0, cp0_we_o 1 cycle.
- AdEL-data + Ov, addr=0x8000_0003, in_ds=1, pc=0xBFC0_2004 -> exc_code_o=0x04, badvaddr_o=0x8000_0003, epc_o=0xBFC0_2000, bd_o=1.
- hw_int_i[0] high, IM[2]=1, IE=1, EXL=0, commit with mem_en=0 after SYNC_STAGES+1 cycles -> exc_code_o=0x00; same with mem_en=1 -> no flush.
- ERET, cp0_epc_i=0xBFC0_0700 -> eret_o pulse, flush_pc_o=0xBFC0_0700, cp0_we_o=0.
- flush_ack_i delayed 5 cycles, DRAIN_CYC=2 -> flush_o held 5 cycles, cm_ready_o low 5+2 cycles, back-to-back Sys commit accepted only afterwards.
- resetn pulled low while in FLUSH -> flush_o=0 immediately, cm_ready_o=1 after release.
